// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
//
// Purpose:
//   Groups every handshake and data signal around the instruction fetch
//   controller. This covers the redirect request from execute, the
//   instruction-memory request/response channel and the decode-facing
//   instruction channel. Clock and reset are not in this bundle; they stay
//   plain ports on the modules.
//
// Signals:
//   redirect_valid  execute -> fetch   redirect request (branch/jump/trap)
//   redirect_pc     execute -> fetch   redirect target (low two bits ignored)
//   imem_req_valid  fetch   -> imem    request presented
//   imem_req_ready  imem    -> fetch   request accepted this cycle
//   imem_req_addr   fetch   -> imem    word-aligned request address
//   imem_rsp_valid  imem    -> fetch   response word valid
//   imem_rsp_data   imem    -> fetch   response instruction word
//   if_valid        fetch   -> decode  instruction presented
//   if_ready        decode  -> fetch   decode accepts the instruction
//   if_pc           fetch   -> decode  PC of the presented instruction
//   if_inst         fetch   -> decode  presented instruction word
//
// Modports:
//   master  the fetch controller side
//   slave   the environment side (execute, instruction memory and decode)
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;

    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output if_valid,
        input  if_ready,
        output if_pc,
        output if_inst
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  if_valid,
        output if_ready,
        input  if_pc,
        input  if_inst
    );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Purpose:
//   Instruction fetch controller. It keeps at most one instruction-memory
//   request outstanding and presents each fetched word to decode. It also
//   handles redirects from execute at any point in the fetch cycle.
//   The controller cycles through three states:
//     REQ  : request presented at the current pc, waiting for acceptance
//     WAIT : request accepted, waiting for the response word
//     HOLD : instruction presented to decode, waiting for if_ready
//   A redirect always wins. It loads the new (word-aligned) pc on the same edge.
//   If a response is still in flight, a single drop flag marks that response
//   so it is discarded when it arrives.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    fetch_ctrl_if.master (redirect, imem request/response, decode)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.master  bus
);

    // Instruction word presented before anything has been fetched (addi x0,x0,0).
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_drop;
    logic        r_req_valid;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;

    logic [31:0] w_redirect_target;
    logic [31:0] w_pc_inc;
    logic        w_req_fire;
    logic        w_unused_redirect_bits;

    // Fetch addresses are always word aligned, so the low target bits are dropped.
    assign w_redirect_target      = {bus.redirect_pc[31:2], 2'b00};
    assign w_unused_redirect_bits = ^bus.redirect_pc[1:0];

    // Plain 32-bit add: 32'hFFFF_FFFC + 4 wraps to zero.
    assign w_pc_inc = r_pc + 32'd4;

    // r_req_valid is only set in REQ, so this is the accept handshake.
    assign w_req_fire = r_req_valid && bus.imem_req_ready;

    // ------------------------------------------------------------------
    // Controller FSM. The valid flags are registered next to the state so
    // that each flag is high in exactly one state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_REQ;
            r_pc        <= {RESET_PC[31:2], 2'b00};
            r_drop      <= 1'b0;
            r_req_valid <= 1'b1;
            r_if_valid  <= 1'b0;
            r_if_pc     <= 32'h0000_0000;
            r_if_inst   <= NOP_INST;
        end else begin
            unique case (r_state)
                ST_REQ: begin
                    // A redirect without acceptance only retargets the
                    // request. The address may change while valid stays high.
                    if (bus.redirect_valid) begin
                        r_pc <= w_redirect_target;
                    end
                    if (w_req_fire) begin
                        r_state     <= ST_WAIT;
                        r_req_valid <= 1'b0;
                        // The request just accepted was for the old pc. Its
                        // response must be thrown away if a redirect came
                        // with it.
                        r_drop      <= bus.redirect_valid;
                    end
                end

                ST_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (bus.redirect_valid || r_drop) begin
                            // This response is stale, so discard it and
                            // fetch again at the current or new pc. Taking
                            // the response closes the request, so the flag
                            // clears even when a redirect arrives now.
                            if (bus.redirect_valid) begin
                                r_pc <= w_redirect_target;
                            end
                            r_drop      <= 1'b0;
                            r_state     <= ST_REQ;
                            r_req_valid <= 1'b1;
                        end else begin
                            r_if_inst  <= bus.imem_rsp_data;
                            r_if_pc    <= r_pc;
                            r_state    <= ST_HOLD;
                            r_if_valid <= 1'b1;
                        end
                    end else if (bus.redirect_valid) begin
                        // Only the last target counts. One flag is enough
                        // because only one response can still be in flight.
                        r_pc   <= w_redirect_target;
                        r_drop <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    // A response strobe here is a protocol violation and is
                    // ignored, because imem_rsp_valid is never looked at.
                    if (bus.redirect_valid) begin
                        // The held instruction is on the wrong path, so drop
                        // it even when decode accepts it this same cycle.
                        r_pc        <= w_redirect_target;
                        r_state     <= ST_REQ;
                        r_if_valid  <= 1'b0;
                        r_req_valid <= 1'b1;
                    end else if (bus.if_ready) begin
                        r_pc        <= w_pc_inc;
                        r_state     <= ST_REQ;
                        r_if_valid  <= 1'b0;
                        r_req_valid <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_REQ;
                    r_drop      <= 1'b0;
                    r_req_valid <= 1'b1;
                    r_if_valid  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Both valids are gated with rst_n, so they are low for the
    // whole reset. The first request shows up as soon as rst_n goes high.
    // ------------------------------------------------------------------
    assign bus.imem_req_valid = r_req_valid && rst_n;
    assign bus.imem_req_addr  = r_pc;
    assign bus.if_valid       = r_if_valid && rst_n;
    assign bus.if_pc          = r_if_pc;
    assign bus.if_inst        = r_if_inst;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; reset is synchronous and active-low.
REQ-004 The block SHALL have port redirect_valid, input, 1, a branch/jump/trap redirect request from the execute stage.
REQ-005 The block SHALL have port redirect_pc, input, 32, the redirect target.
REQ-006 The block SHALL have port imem_req_valid, output, 1, an instruction-memory request is presented.
REQ-007 The block SHALL have port imem_req_ready, input, 1, instruction memory accepts the request.
REQ-008 The block SHALL have port imem_req_addr, output, 32, the request address, word-aligned.
REQ-009 The block SHALL have port imem_rsp_valid, input, 1, the response is valid, arriving 1 or more cycles after acceptance.
REQ-010 The block SHALL have port imem_rsp_data, input, 32, the response instruction word.
REQ-011 The block SHALL have port if_valid, output, 1, the decode-facing instruction is valid.
REQ-012 The block SHALL have port if_ready, input, 1, decode accepts the instruction.
REQ-013 The block SHALL have port if_pc, output, 32, the PC of the presented instruction.
REQ-014 The block SHALL have port if_inst, output, 32, the presented instruction word.

Function
REQ-015 The block SHALL implement FSM states REQ, WAIT and HOLD, with at most one imem request outstanding.
REQ-016 In REQ, the block SHALL drive imem_req_valid=1 and imem_req_addr=pc; on req_valid&&req_ready it SHALL go to WAIT.
REQ-017 In WAIT, on imem_rsp_valid with the drop flag clear, the block SHALL register if_inst=rsp_data and if_pc=pc, and go to HOLD.
REQ-018 In HOLD, if_valid SHALL be 1 and if_pc/if_inst SHALL be held stable; on if_ready the block SHALL set pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) and go to REQ.
REQ-019 if_valid SHALL be 1 only in HOLD, and imem_req_valid SHALL be 1 only in REQ.
REQ-020 A redirect SHALL take priority over all other events, setting pc<={redirect_pc[31:2],2'b00} in the same edge.
REQ-021 Redirect in HOLD (with or without if_ready): the held instruction SHALL be discarded, there SHALL be no pc+4, and the next state SHALL be REQ.
REQ-022 Redirect in REQ without handshake: the state SHALL stay REQ and imem_req_addr SHALL show the new pc the next cycle; the address may change while valid is asserted.
REQ-023 Redirect in REQ with handshake in the same cycle: the next state SHALL be WAIT with the drop flag set.
REQ-024 Redirect in WAIT without rsp_valid: the drop flag SHALL be set and the state SHALL stay WAIT.
REQ-025 Redirect in WAIT with rsp_valid in the same cycle: the response SHALL be discarded, the drop flag SHALL NOT be set, and the next state SHALL be REQ.
REQ-026 In WAIT, rsp_valid with the drop flag set SHALL discard the data, clear the flag and go to REQ at the current (redirected) pc.
REQ-027 Multiple redirects while in WAIT SHALL keep only the last target, with a single drop flag.
REQ-028 Minimum throughput with a 1-cycle memory and if_ready=1 SHALL be one instruction per 3 cycles.
REQ-029 imem_rsp_valid in REQ or HOLD is a protocol violation; the block SHALL ignore it.

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL set state=REQ, pc=RESET_PC, drop=0, if_pc=0 and if_inst=32'h0000_0013 (NOP).
REQ-031 During reset, imem_req_valid and if_valid SHALL be forced to 0, and the first request SHALL occur in the first cycle after rst_n=1.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding request, and a late response after reset SHALL be ignored because the state is REQ.

Verification
REQ-033 Reset release, req_ready=1, 1-cycle response 32'hDEADBEEF, if_ready=1: imem_req_addr=0 and then 4; if_pc=0 with if_inst=DEADBEEF valid on cycle 3.
REQ-034 Decode stall: if_ready=0 for 5 cycles in HOLD: if_pc/if_inst stable, no imem request, pc advances only after if_ready=1.
REQ-035 Redirect to 32'h0000_0103 while WAIT, response 2 cycles later: response dropped, if_valid stays 0, next request address 32'h0000_0100.
REQ-036 Redirect coincident with if_ready in HOLD at pc=8 to 32'h40: next address 32'h40, not 32'hC.
REQ-037 Redirect and rsp_valid in the same WAIT cycle, target 32'h80: no if_valid; next cycle request 32'h80.
REQ-038 pc=32'hFFFF_FFFC accepted by decode: next request address 32'h0000_0000.
